// File: rtl/psum_collect.sv
// psum_collect
//   Accumulates a wide vector of partial sums over 1..8 rounds and then
//   drains the result downstream as a sequence of narrower beats.
//
//   Parameters
//     LANES       number of partial-sum lanes on Psum
//     LW          width of one lane (unsigned, accumulation wraps mod 2^LW)
//     BEAT_LANES  lanes per output beat (LANES must be a multiple)
//
//   Ports
//     clk         clock, all state changes on rising edge
//     rst_n       asynchronous active-low reset
//     Psum_valid  one-cycle strobe qualifying Psum
//     Psum        LANES*LW input vector, lane k at [k*LW +: LW]
//     wround      rounds-minus-one for the batch, sampled on its first strobe
//     out_valid   out_data holds a valid beat
//     out_ready   downstream accepts the beat when out_valid && out_ready
//     out_data    BEAT_LANES*LW beat, lowest lane in the LSBs
//     out_last    marks the final beat of a batch
//     busy        high whenever a batch is being accumulated or drained
//     drop_err    sticky flag: a strobe arrived while draining and was dropped
module psum_collect #(
  parameter int LANES      = 36,
  parameter int LW         = 24,
  parameter int BEAT_LANES = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       Psum_valid,
  input  logic [LANES*LW-1:0]        Psum,
  input  logic [2:0]                 wround,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BEAT_LANES*LW-1:0]   out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       drop_err
);

  localparam int NBEATS = LANES / BEAT_LANES;
  localparam int BEAT_W = BEAT_LANES * LW;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACC   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]          state_reg;
  logic [LANES*LW-1:0] acc_reg;
  logic [LANES*LW-1:0] acc_sum;
  logic [2:0]          rcnt_reg;
  logic [2:0]          rtarget_reg;
  logic [2:0]          rcnt_next;
  logic [BW-1:0]       bcnt_reg;
  logic                drop_err_reg;
  logic                draining;
  logic                is_last;
  logic [BEAT_W-1:0]   beat_sel [NBEATS];

  // Per-lane wrapping adders; carries never cross lane boundaries.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane_add
      assign acc_sum[gi*LW +: LW] = acc_reg[gi*LW +: LW] + Psum[gi*LW +: LW];
    end
    for (gi = 0; gi < NBEATS; gi++) begin : g_beat
      assign beat_sel[gi] = acc_reg[gi*BEAT_W +: BEAT_W];
    end
  endgenerate

  assign rcnt_next = rcnt_reg + 3'd1;
  assign draining  = (state_reg == ST_DRAIN);
  assign is_last   = draining && (bcnt_reg == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      acc_reg      <= '0;
      rcnt_reg     <= '0;
      rtarget_reg  <= '0;
      bcnt_reg     <= '0;
      drop_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (Psum_valid) begin
            // First strobe loads directly and latches the round count, so
            // later wround changes cannot affect this batch.
            acc_reg     <= Psum;
            rcnt_reg    <= 3'd0;
            rtarget_reg <= wround;
            state_reg   <= (wround == 3'd0) ? ST_DRAIN : ST_ACC;
          end
        end
        ST_ACC: begin
          if (Psum_valid) begin
            acc_reg  <= acc_sum;
            rcnt_reg <= rcnt_next;
            if (rcnt_next == rtarget_reg) begin
              state_reg <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Strobes while draining (including the exit cycle) are lost.
          if (Psum_valid) begin
            drop_err_reg <= 1'b1;
          end
          if (out_ready) begin
            if (is_last) begin
              bcnt_reg  <= '0;
              state_reg <= ST_IDLE;
            end else begin
              bcnt_reg <= bcnt_reg + BW'(1);
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Beat output is purely a mux on registered state, so it holds steady
  // for as long as the consumer stalls.
  always_comb begin
    out_data = '0;
    if (draining) begin
      out_data = beat_sel[bcnt_reg];
    end
  end

  assign out_valid = draining;
  assign out_last  = is_last;
  assign busy      = (state_reg != ST_IDLE);
  assign drop_err  = drop_err_reg;

endmodule
